// File: rtl/uart_fifo_drain_sched.sv
// Read/write sequencer for the 128x8 UART FIFO: gates host writes, drains bytes to the tx shifter.
// Optional sticky drop counter (ovf_count) enabled by defining UART_FIFO_OVF_COUNT_EN.
module uart_fifo_drain_sched #(
    parameter int unsigned RD_LATENCY = 2,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wr_req,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  fifo_write_n,
    output logic [DATA_WIDTH-1:0] fifo_data_in,
    output logic                  fifo_read_n,
    input  logic [DATA_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_full,
    input  logic                  fifo_empty,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  overflow,
`ifdef UART_FIFO_OVF_COUNT_EN
    output logic [7:0]            ovf_count,
`endif
    input  logic                  clr_overflow,
    output logic                  busy
);

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StWait,
        StPresent
    } state_e;

    localparam logic [2:0] LatInit = 3'(RD_LATENCY);

    state_e                state_q, state_d;
    logic [2:0]            lat_cnt_q, lat_cnt_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                  tx_valid_q, tx_valid_d;
    logic                  overflow_q, overflow_d;
    logic                  capture;
    logic                  drop;

    // Full is sampled as-is; a read issued in the same cycle does not rescue the write.
    assign drop         = wr_req & fifo_full;
    assign fifo_write_n = ~(wr_req & ~fifo_full);
    assign fifo_data_in = wr_data;

    assign fifo_read_n = (state_q != StRead);
    assign busy        = (state_q != StIdle);
    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_valid_q;
    assign overflow    = overflow_q;

    always_comb begin
        state_d    = state_q;
        lat_cnt_d  = lat_cnt_q;
        capture    = 1'b0;
        tx_valid_d = tx_valid_q;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    state_d = StRead;
                end
            end
            StRead: begin
                lat_cnt_d = LatInit;
                state_d   = StWait;
            end
            StWait: begin
                lat_cnt_d = lat_cnt_q - 3'd1;
                if (lat_cnt_q == 3'd1) begin
                    capture    = 1'b1;
                    tx_valid_d = 1'b1;
                    state_d    = StPresent;
                end
            end
            StPresent: begin
                if (tx_valid_q && tx_ready) begin
                    tx_valid_d = 1'b0;
                    state_d    = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        tx_data_d = capture ? fifo_data_out : tx_data_q;
    end

    // Set beats clear when a drop coincides with clr_overflow.
    always_comb begin
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            lat_cnt_q  <= 3'd0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lat_cnt_q  <= lat_cnt_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef UART_FIFO_OVF_COUNT_EN
    logic [7:0] ovf_count_q, ovf_count_d;

    always_comb begin
        ovf_count_d = ovf_count_q;
        if (clr_overflow) begin
            ovf_count_d = drop ? 8'd1 : 8'd0;
        end else if (drop && ovf_count_q != 8'hFF) begin
            ovf_count_d = ovf_count_q + 8'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ovf_count_q <= 8'd0;
        end else begin
            ovf_count_q <= ovf_count_d;
        end
    end

    assign ovf_count = ovf_count_q;
`endif

endmodule

// File: tb/tb_uart_fifo_drain_sched.sv
// Bench for uart_fifo_drain_sched: queue-based FIFO model with delayed read data and a
// delivery scoreboard. Checks ovf_count too when UART_FIFO_OVF_COUNT_EN is defined.
module tb_uart_fifo_drain_sched;

    localparam int LAT = 2;
    localparam int CAP = 127;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       wr_req = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       fifo_write_n;
    logic [7:0] fifo_data_in;
    logic       fifo_read_n;
    logic [7:0] fifo_data_out = 8'h00;
    logic       fifo_full = 1'b0;
    logic       fifo_empty = 1'b1;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    logic       overflow;
    logic       clr_overflow = 1'b0;
    logic       busy;
`ifdef UART_FIFO_OVF_COUNT_EN
    logic [7:0] ovf_count;
`endif

    uart_fifo_drain_sched #(
        .RD_LATENCY (LAT),
        .DATA_WIDTH (8)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .wr_req        (wr_req),
        .wr_data       (wr_data),
        .fifo_write_n  (fifo_write_n),
        .fifo_data_in  (fifo_data_in),
        .fifo_read_n   (fifo_read_n),
        .fifo_data_out (fifo_data_out),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .overflow      (overflow),
`ifdef UART_FIFO_OVF_COUNT_EN
        .ovf_count     (ovf_count),
`endif
        .clr_overflow  (clr_overflow),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] pipe[LAT];
    int         cyc = 0;
    int         strobes = 0;
    int         delivered = 0;
    int         last_strobe = -1000;
    logic       s_write_n, s_read_n, s_tx_valid, s_ovf, s_busy;
    logic [7:0] s_tx_data;
    int         s_cyc;
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic       exp_ovf = 1'b0;
    int         exp_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic refresh_flags();
        fifo_empty    = (fifo_q.size() == 0);
        fifo_full     = (fifo_q.size() >= CAP);
        fifo_data_out = pipe[LAT-1];
    endtask

    // One clock: check at the falling edge, then advance the FIFO and reference models.
    task automatic tick();
        logic acc, drop, rd, hs;
        @(negedge clock);
        s_write_n  = fifo_write_n;
        s_read_n   = fifo_read_n;
        s_tx_valid = tx_valid;
        s_tx_data  = tx_data;
        s_ovf      = overflow;
        s_busy     = busy;
        s_cyc      = cyc;
        acc  = wr_req && (fifo_q.size() < CAP);
        drop = wr_req && !acc;
        chk("fifo_write_n", s_write_n, !acc);
        if (acc) chk("fifo_data_in", fifo_data_in, wr_data);
        chk("overflow", s_ovf, exp_ovf);
`ifdef UART_FIFO_OVF_COUNT_EN
        chk("ovf_count", ovf_count, exp_cnt);
`endif
        if (prev_valid && !prev_ready) begin
            chk("tx_valid_held", s_tx_valid, 1);
            chk("tx_data_held", s_tx_data, prev_data);
        end
        rd = !s_read_n;
        if (rd) begin
            chk("no_underflow_read", fifo_q.size() > 0, 1);
            chk("strobe_while_valid", s_tx_valid, 0);
            chk("strobe_spacing_ok", (cyc - last_strobe) >= LAT + 2, 1);
            last_strobe = cyc;
            strobes++;
        end
        hs = s_tx_valid && tx_ready;
        if (hs) begin
            chk("tx_byte_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) chk("tx_data", s_tx_data, exp_q.pop_front());
            delivered++;
        end
        prev_valid = s_tx_valid;
        prev_ready = tx_ready;
        prev_data  = s_tx_data;
        @(posedge clock);
        #1;
        for (int i = LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
        if (rd && fifo_q.size() > 0) pipe[0] = fifo_q.pop_front();
        else pipe[0] = 8'($urandom);
        if (acc) begin
            fifo_q.push_back(wr_data);
            exp_q.push_back(wr_data);
        end
        if (drop) exp_ovf = 1'b1;
        else if (clr_overflow) exp_ovf = 1'b0;
        if (clr_overflow) exp_cnt = drop ? 1 : 0;
        else if (drop && exp_cnt < 255) exp_cnt++;
        refresh_flags();
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wr_req = 1'b0;
        clr_overflow = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        for (int i = 0; i < LAT; i++) pipe[i] = 8'h00;
        exp_ovf = 1'b0;
        exp_cnt = 0;
        prev_valid = 1'b0;
        refresh_flags();
        repeat (2) @(posedge clock);
        #1;
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_read_n", fifo_read_n, 1);
        chk("rst_write_n", fifo_write_n, 1);
        chk("rst_overflow", overflow, 0);
        reset = 1'b0;
    endtask

    initial begin
        int t_ne, guard, s0;

        // Reset state.
        do_reset();

        // Single byte through an empty FIFO.
        tx_ready = 1'b1;
        wr_req = 1'b1; wr_data = 8'hA5;
        tick();
        wr_req = 1'b0;
        tick();
        t_ne = s_cyc;
        chk("t1_read_n_idle", s_read_n, 1);
        tick();
        chk("t1_read_strobe", s_read_n, 0);
        guard = 0;
        do begin tick(); guard++; end while (!s_tx_valid && guard < 20);
        chk("t1_valid_latency", s_cyc - t_ne, LAT + 2);
        chk("t1_tx_data", s_tx_data, 8'hA5);
        repeat (4) tick();
        chk("t1_delivered", delivered, 1);

        // Back-pressure: five bytes queued, only one read while tx_ready is low.
        tx_ready = 1'b0;
        s0 = strobes;
        for (int i = 1; i <= 5; i++) begin
            wr_req = 1'b1; wr_data = 8'(i);
            tick();
        end
        wr_req = 1'b0;
        repeat (20) tick();
        chk("t2_one_strobe", strobes - s0, 1);
        chk("t2_valid_held", s_tx_valid, 1);
        chk("t2_first_byte", s_tx_data, 8'h01);
        tx_ready = 1'b1;
        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin tick(); guard++; end
        chk("t2_drained", exp_q.size(), 0);
        chk("t2_strobes", strobes - s0, 5);

        // Fill to full, drop a write, clear the flag.
        tx_ready = 1'b0;
        guard = 0;
        while (fifo_q.size() < CAP && guard < 300) begin
            wr_req = 1'b1; wr_data = 8'(guard);
            tick(); guard++;
        end
        chk("t3_full", fifo_full, 1);
        wr_data = 8'hFF;
        tick();
        wr_req = 1'b0;
        tick();
        chk("t3_overflow_set", s_ovf, 1);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        tick();
        chk("t3_overflow_clr", s_ovf, 0);
`ifdef UART_FIFO_OVF_COUNT_EN
        wr_req = 1'b1;
        repeat (300) tick();
        wr_req = 1'b0;
        tick();
        chk("t3_ovf_count_sat", ovf_count, 255);
        clr_overflow = 1'b1; wr_req = 1'b1;
        tick();
        clr_overflow = 1'b0; wr_req = 1'b0;
        tick();
        chk("t3_ovf_count_clr_drop", ovf_count, 1);
`endif
        tx_ready = 1'b1;
        guard = 0;
        while (exp_q.size() != 0 && guard < 2000) begin tick(); guard++; end
        chk("t3_drained", exp_q.size(), 0);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;

        // 130 back-to-back writes while draining: exercises the pointer wrap, no drops.
        for (int i = 0; i < 130; i++) begin
            wr_req = 1'b1; wr_data = 8'($urandom);
            tick();
        end
        wr_req = 1'b0;
        guard = 0;
        while (exp_q.size() != 0 && guard < 2000) begin tick(); guard++; end
        chk("t4_drained", exp_q.size(), 0);
        chk("t4_no_overflow", s_ovf, 0);

        // Reset while the 0x3C read is waiting on FIFO latency.
        wr_req = 1'b1; wr_data = 8'h3C;
        tick();
        wr_req = 1'b0;
        tick();
        tick();
        #2;
        chk("t5_busy_in_wait", busy, 1);
        reset = 1'b1;
        #1;
        chk("t5_async_tx_valid", tx_valid, 0);
        chk("t5_async_busy", busy, 0);
        chk("t5_async_read_n", fifo_read_n, 1);
        do_reset();
        s0 = strobes;
        repeat (20) tick();
        chk("t5_no_strobe", strobes - s0, 0);

        // Empty FIFO with tx_ready held high.
        tx_ready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            chk("t6_read_n", s_read_n, 1);
            chk("t6_tx_valid", s_tx_valid, 0);
        end

        // Random traffic against the scoreboard.
        for (int i = 0; i < 600; i++) begin
            wr_req       = ($urandom_range(0, 9) < 4);
            wr_data      = 8'($urandom);
            tx_ready     = 1'($urandom_range(0, 1));
            clr_overflow = ($urandom_range(0, 19) == 0);
            tick();
        end
        wr_req = 1'b0; clr_overflow = 1'b0; tx_ready = 1'b1;
        guard = 0;
        while (exp_q.size() != 0 && guard < 2000) begin tick(); guard++; end
        chk("rand_drained", exp_q.size(), 0);
        repeat (LAT + 4) tick();
        chk("rand_idle", s_busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
